// File: rtl/fetch_status_unit.sv
// Fetch stage state: program counter, instruction register with its fetch address,
// and the registered V/C/N/Z condition flags presented to the control unit.
module fetch_status_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  PS,
    input  logic        PCsel,
    input  logic        IL,
    input  logic        SL,
    input  logic [63:0] constant,
    input  logic [63:0] reg_a,
    input  logic [31:0] instr_in,
    input  logic [4:0]  alu_status,
    output logic [63:0] PC,
    output logic [31:0] I,
    output logic [4:0]  status,
    output logic [63:0] link_addr,
    output logic        ir_valid
);

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

    logic [63:0] pc_q, pc_d;
    logic [63:0] instr_addr_q, instr_addr_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [3:0]  flags_q, flags_d;

    logic [63:0] target;
    logic [63:0] branch_offset;

    assign target        = PCsel ? constant : reg_a;
    // Word offset to byte offset; bits [63:62] of the target fall off the top.
    assign branch_offset = {target[61:0], 2'b00};

    // Relative branches are based on the fetch address of the branch itself,
    // never on the already-advanced PC.
    always_comb begin
        pc_d = pc_q;
        unique case (PS)
            PS_HOLD: pc_d = pc_q;
            PS_INC:  pc_d = pc_q + 64'd4;
            PS_LOAD: pc_d = target;
            PS_REL:  pc_d = instr_addr_q + branch_offset;
            default: pc_d = pc_q;
        endcase
    end

    always_comb begin
        ir_d         = ir_q;
        instr_addr_d = instr_addr_q;
        ir_valid_d   = ir_valid_q;
        if (IL) begin
            ir_d         = instr_in;
            instr_addr_d = pc_q;
            ir_valid_d   = 1'b1;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (SL) begin
            flags_d = alu_status[4:1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= 64'd0;
            instr_addr_q <= 64'd0;
            ir_q         <= 32'd0;
            ir_valid_q   <= 1'b0;
            flags_q      <= 4'd0;
        end else begin
            pc_q         <= pc_d;
            instr_addr_q <= instr_addr_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            flags_q      <= flags_d;
        end
    end

    assign PC        = pc_q;
    assign I         = ir_q;
    assign ir_valid  = ir_valid_q;
    // Live zero bit bypasses the register so CBZ/CBNZ resolve in the same cycle.
    assign status    = {flags_q, alu_status[0]};
    assign link_addr = instr_addr_q + 64'd4;

endmodule

// File: tb/tb_fetch_status_unit.sv
// Directed-vector bench for fetch_status_unit: reset, fetch, absolute/relative
// branches, wrap-around, status flag load/hold and reset override.
module tb_fetch_status_unit;

    logic        clock;
    logic        reset;
    logic [1:0]  PS;
    logic        PCsel;
    logic        IL;
    logic        SL;
    logic [63:0] constant;
    logic [63:0] reg_a;
    logic [31:0] instr_in;
    logic [4:0]  alu_status;
    logic [63:0] PC;
    logic [31:0] I;
    logic [4:0]  status;
    logic [63:0] link_addr;
    logic        ir_valid;

    int assert_count = 0;
    int fail_count   = 0;

    fetch_status_unit dut (
        .clock      (clock),
        .reset      (reset),
        .PS         (PS),
        .PCsel      (PCsel),
        .IL         (IL),
        .SL         (SL),
        .constant   (constant),
        .reg_a      (reg_a),
        .instr_in   (instr_in),
        .alu_status (alu_status),
        .PC         (PC),
        .I          (I),
        .status     (status),
        .link_addr  (link_addr),
        .ir_valid   (ir_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        PS         = 2'b11;
        PCsel      = 1'b1;
        IL         = 1'b1;
        SL         = 1'b1;
        constant   = 64'd7;
        reg_a      = 64'h55;
        instr_in   = 32'hDEADBEEF;
        alu_status = 5'b11111;
        #1;
        step();
        step();
        $display("txn reset: PC=%h I=%h status=%b link=%h v=%b", PC, I, status, link_addr, ir_valid);
        chk("rst_pc",     PC,        64'd0);
        chk("rst_ir",     {32'd0, I}, 64'd0);
        chk("rst_valid",  {63'd0, ir_valid}, 64'd0);
        chk("rst_link",   link_addr, 64'd4);
        chk("rst_status", {59'd0, status}, 64'h01);

        // Fetch from PC=0
        reset      = 1'b0;
        PS         = 2'b01;
        IL         = 1'b1;
        SL         = 1'b0;
        alu_status = 5'b00000;
        instr_in   = 32'h8B020020;
        step();
        $display("txn fetch: PC=%h I=%h link=%h v=%b", PC, I, link_addr, ir_valid);
        chk("fetch_ir",    {32'd0, I}, 64'h8B020020);
        chk("fetch_pc",    PC,        64'd4);
        chk("fetch_valid", {63'd0, ir_valid}, 64'd1);
        chk("fetch_link",  link_addr, 64'd4);

        // Absolute load to 0x100 with IL=0: instruction side holds
        PS = 2'b10; PCsel = 1'b0; reg_a = 64'h100; IL = 1'b0; instr_in = 32'h12345678;
        step();
        $display("txn abs100: PC=%h I=%h link=%h", PC, I, link_addr);
        chk("abs100_pc",   PC,        64'h100);
        chk("abs100_ir",   {32'd0, I}, 64'h8B020020);
        chk("abs100_link", link_addr, 64'd4);

        // Fetch at 0x100
        PS = 2'b01; IL = 1'b1; instr_in = 32'hB4000041;
        step();
        $display("txn fetch100: PC=%h link=%h", PC, link_addr);
        chk("fetch100_pc",   PC,        64'h104);
        chk("fetch100_link", link_addr, 64'h104);

        // Relative branch by -2 words from instr_addr 0x100
        PS = 2'b11; PCsel = 1'b1; IL = 1'b0; constant = 64'hFFFFFFFFFFFFFFFE;
        step();
        $display("txn rel_neg: PC=%h link=%h", PC, link_addr);
        chk("rel_neg_pc",   PC,        64'hF8);
        chk("rel_neg_link", link_addr, 64'h104);

        // Rebuild instr_addr=0x100, PC=0x104, then branch by +3 words
        PS = 2'b10; PCsel = 1'b0; reg_a = 64'h100;
        step();
        PS = 2'b01; IL = 1'b1;
        step();
        PS = 2'b11; PCsel = 1'b1; IL = 1'b0; constant = 64'd3;
        step();
        $display("txn rel_pos: PC=%h", PC);
        chk("rel_pos_pc", PC, 64'h10C);

        // IL=1 with PS=11: base is the pre-edge instr_addr (0x100)
        PS = 2'b11; PCsel = 1'b1; IL = 1'b1; constant = 64'd1; instr_in = 32'h17000001;
        step();
        $display("txn rel_il: PC=%h I=%h link=%h", PC, I, link_addr);
        chk("rel_il_pc",   PC,        64'h104);
        chk("rel_il_link", link_addr, 64'h110);
        chk("rel_il_ir",   {32'd0, I}, 64'h17000001);

        // Shift discards target bits [63:62]: base 0x10C + 4
        PS = 2'b11; PCsel = 1'b0; IL = 1'b0; reg_a = 64'hC000000000000001;
        step();
        $display("txn rel_shift: PC=%h", PC);
        chk("rel_shift_pc", PC, 64'h110);

        // Absolute branch to 0x2000
        PS = 2'b10; PCsel = 1'b0; reg_a = 64'h2000;
        step();
        $display("txn abs2000: PC=%h", PC);
        chk("abs2000_pc", PC, 64'h2000);

        // Load near the top, then fetch: PC wraps to 0, link wraps to 0
        reg_a = 64'hFFFFFFFFFFFFFFFC;
        step();
        chk("abs_top_pc", PC, 64'hFFFFFFFFFFFFFFFC);
        PS = 2'b01; IL = 1'b1;
        step();
        $display("txn wrap: PC=%h link=%h", PC, link_addr);
        chk("wrap_pc",   PC,        64'd0);
        chk("wrap_link", link_addr, 64'd0);

        // Hold
        PS = 2'b00; IL = 1'b0;
        step();
        $display("txn hold: PC=%h", PC);
        chk("hold_pc", PC, 64'd0);

        // Status load
        SL = 1'b1; alu_status = 5'b10110;
        step();
        $display("txn sl_load: status=%b", status);
        chk("sl_load", {59'd0, status}, 64'h16);

        // SL=0: flags hold, live bit 0 visible within the same cycle
        SL = 1'b0; alu_status = 5'b01001;
        #1;
        chk("sl_live", {59'd0, status}, 64'h17);
        step();
        $display("txn sl_hold: status=%b", status);
        chk("sl_hold", {59'd0, status}, 64'h17);

        // Live zero drop
        alu_status = 5'b01000;
        #1;
        chk("sl_live0", {59'd0, status}, 64'h16);

        // Second load
        SL = 1'b1; alu_status = 5'b01001;
        step();
        $display("txn sl_load2: status=%b", status);
        chk("sl_load2", {59'd0, status}, 64'h09);

        // Advance to a nonzero state before mid-operation reset
        SL = 1'b0; PS = 2'b01; IL = 1'b1; instr_in = 32'hAAAA5555;
        step();
        step();
        chk("pre_rst_pc", PC, 64'd8);

        // Reset overrides PS=11, IL=1, SL=1
        reset = 1'b1; PS = 2'b11; IL = 1'b1; SL = 1'b1; PCsel = 1'b1; constant = 64'd5;
        alu_status = 5'b11111;
        step();
        alu_status = 5'b01001;
        #1;
        $display("txn mid_rst: PC=%h I=%h status=%b link=%h v=%b", PC, I, status, link_addr, ir_valid);
        chk("mid_rst_pc",     PC,        64'd0);
        chk("mid_rst_ir",     {32'd0, I}, 64'd0);
        chk("mid_rst_valid",  {63'd0, ir_valid}, 64'd0);
        chk("mid_rst_link",   link_addr, 64'd4);
        chk("mid_rst_status", {59'd0, status}, 64'h01);

        // First edge after reset behaves normally
        reset = 1'b0; PS = 2'b01; IL = 1'b0; SL = 1'b0;
        step();
        $display("txn post_rst: PC=%h v=%b", PC, ir_valid);
        chk("post_rst_pc",    PC, 64'd4);
        chk("post_rst_valid", {63'd0, ir_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
